if_fetch: RTL



---
 rtl/if_fetch_pkg.sv | 20 ++
 rtl/if_fetch.sv | 128 ++++++++++++
 2 files changed

// File: rtl/if_fetch_pkg.sv
// Shared constants and the fetch-state encoding for the instruction-fetch front end.
package if_fetch_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [InstBus-1:0]     ZeroWord  = '0;
  localparam logic [InstAddrBus-1:0] RstPc     = 32'h0;
  localparam logic                   RstEnable = 1'b1;
  localparam logic                   Stop      = 1'b1;
  localparam logic                   NoStop    = 1'b0;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_FETCH,
    FS_VALID,
    FS_DISCARD
  } fetch_state_e;

endpackage

// File: rtl/if_fetch.sv
// IF stage: owns the PC, runs one outstanding req/ack fetch at a time and presents
// the fetched word to IF/ID, honouring stall, flush and delayed-branch redirects.
module if_fetch
  import if_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  output logic        iw_req_o,
  output logic [31:0] iw_addr_o,
  input  logic        iw_ack_i,
  input  logic [31:0] iw_data_i,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_from_if
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  inst_buf;
  logic         pend_br;
  logic [31:0]  pend_tgt;
  logic         br_take;
  logic [31:0]  consume_pc;
  logic         unused_stall;

  // stall[0] never matters: an outstanding request always runs to its ack.
  assign unused_stall = ^{stall[5:3], stall[0]};

  assign br_take = branch_flag_i && (stall[2] == NoStop);
  assign if_inst = inst_buf;

  // NOTE: every branch of the if/else assigns consume_pc, so no latch is inferred.
  always_comb begin
    if (br_take)      consume_pc = branch_target_address_i;
    else if (pend_br) consume_pc = pend_tgt;
    else              consume_pc = pc + 32'd4;
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state            <= FS_IDLE;
      pc               <= RstPc;
      inst_buf         <= ZeroWord;
      pend_br          <= 1'b0;
      pend_tgt         <= RstPc;
      iw_req_o         <= 1'b0;
      iw_addr_o        <= RstPc;
      if_pc            <= RstPc;
      stallreq_from_if <= 1'b1;
    end else begin
      case (state)
        FS_IDLE: begin
          state     <= FS_FETCH;
          iw_req_o  <= 1'b1;
          iw_addr_o <= pc;
        end

        FS_FETCH: begin
          if (flush) begin
            pc      <= new_pc;
            pend_br <= 1'b0;
            // An ack on the flush edge closes the old request, so re-issue at once.
            if (iw_ack_i) iw_addr_o <= new_pc;
            else          state     <= FS_DISCARD;
          end else begin
            if (br_take) begin
              pend_br  <= 1'b1;
              pend_tgt <= branch_target_address_i;
            end
            if (iw_ack_i) begin
              state            <= FS_VALID;
              inst_buf         <= iw_data_i;
              iw_req_o         <= 1'b0;
              if_pc            <= pc;
              stallreq_from_if <= 1'b0;
            end
          end
        end

        FS_VALID: begin
          if (flush || (stall[1] == NoStop)) begin
            state            <= FS_FETCH;
            pend_br          <= 1'b0;
            pc               <= flush ? new_pc : consume_pc;
            iw_addr_o        <= flush ? new_pc : consume_pc;
            iw_req_o         <= 1'b1;
            inst_buf         <= ZeroWord;
            if_pc            <= RstPc;
            stallreq_from_if <= 1'b1;
          end else if (br_take) begin
            pend_br  <= 1'b1;
            pend_tgt <= branch_target_address_i;
          end
        end

        FS_DISCARD: begin
          // The old address stays on the bus until its ack; that data is dropped.
          if (flush) begin
            pc      <= new_pc;
            pend_br <= 1'b0;
            if (iw_ack_i) begin
              state     <= FS_FETCH;
              iw_addr_o <= new_pc;
            end
          end else begin
            if (br_take) begin
              pend_br  <= 1'b1;
              pend_tgt <= branch_target_address_i;
            end
            if (iw_ack_i) begin
              state     <= FS_FETCH;
              iw_addr_o <= pc;
            end
          end
        end

        default: state <= FS_IDLE;
      endcase
    end
  end

endmodule
